// File: rtl/input_conditioner_pkg.sv
// Shared types and defaults for the input conditioner.
// State encodings are fixed so they can be observed in the debugger.
package input_conditioner_pkg;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        PEND_HIGH = 2'd1,
        HIGH      = 2'd2,
        PEND_LOW  = 2'd3
    } cond_state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/input_conditioner_sync_chain.sv
// Multi-flop synchronizer for one asynchronous bit.
// Plain flop-to-flop chain so every stage gets a full period to settle.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            stages <= '0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Synchronizes and debounces a raw switch input.
// Produces a clean level plus one-cycle rise/fall pulses.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic D_raw,
    output logic D_clean,
    output logic Rise,
    output logic Fall,
    output logic Busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic             s;
    cond_state_t      state;
    cond_state_t      next_state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] next_count;
    logic             cur_clean;
    logic             next_clean;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .Clock (Clock),
        .Resetn(Resetn),
        .d     (D_raw),
        .q     (s)
    );

    always_comb begin
        next_state = state;
        next_count = count;
        unique case (state)
            LOW: begin
                if (s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        next_state = HIGH;
                    end else begin
                        next_state = PEND_HIGH;
                        next_count = ONE;
                    end
                end
            end
            PEND_HIGH: begin
                if (!s) begin
                    next_state = LOW;
                    next_count = '0;
                end else if (count == LAST) begin
                    next_state = HIGH;
                    next_count = '0;
                end else begin
                    next_count = count + ONE;
                end
            end
            HIGH: begin
                if (!s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        next_state = LOW;
                    end else begin
                        next_state = PEND_LOW;
                        next_count = ONE;
                    end
                end
            end
            PEND_LOW: begin
                if (s) begin
                    next_state = HIGH;
                    next_count = '0;
                end else if (count == LAST) begin
                    next_state = LOW;
                    next_count = '0;
                end else begin
                    next_count = count + ONE;
                end
            end
            default: begin
                next_state = LOW;
                next_count = '0;
            end
        endcase
    end

    // Clean level is high in HIGH and while a fall is still unconfirmed
    assign cur_clean  = (state == HIGH) || (state == PEND_LOW);
    assign next_clean = (next_state == HIGH) || (next_state == PEND_LOW);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= LOW;
            count <= '0;
            Rise  <= 1'b0;
            Fall  <= 1'b0;
        end else begin
            state <= next_state;
            count <= next_count;
            Rise  <= next_clean & ~cur_clean;
            Fall  <= ~next_clean & cur_clean;
        end
    end

    assign D_clean = cur_clean;
    assign Busy    = (state == PEND_HIGH) || (state == PEND_LOW);

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Upstream stage for the latch/flip-flop storage elements. Takes an asynchronous, possibly bouncing 1-bit input (switch or key) and produces a clean, clock-synchronous D for the storage stage.
- Also produces single-cycle rise/fall pulses for edge-triggered consumers.
- Internals: a multi-flop synchronizer, then a counter-based debounce state machine.

Parameters:
- SYNC_STAGES, 2, synchronizer flop count; legal range >= 2.
- DEBOUNCE_CYCLES, 4, consecutive synchronized cycles at the new level needed to accept a change; legal range >= 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES)+1, debounce counter width; derived, not overridden.

Ports:
- Clock  input  1  single clock; all state updates on its rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- D_raw  input  1  asynchronous raw input; may bounce.
- D_clean  output  1  debounced level; feeds D of the storage stage.
- Rise  output  1  one-cycle pulse on a 0->1 change of D_clean.
- Fall  output  1  one-cycle pulse on a 1->0 change of D_clean.
- Busy  output  1  high while a candidate change is being qualified.

Behaviour:
- Reset (Resetn=0, asynchronous, any time):
  - Sync chain, counter and state clear to 0 / LOW immediately.
  - D_clean=0, Rise=0, Fall=0, Busy=0.
  - Reset mid-qualification discards the pending change; no pulse is emitted.
- Synchronizer: D_raw shifts through SYNC_STAGES flops. s = last flop. No logic between flops.
- FSM states and transitions:
  - LOW: s=1 -> PEND_HIGH, count=1.
  - PEND_HIGH:
    - s=0 -> LOW, count=0, no pulse.
    - s=1 and count=DEBOUNCE_CYCLES-1 -> HIGH, count=0.
    - otherwise count+1.
  - HIGH: mirror of LOW (s=0 -> PEND_LOW, count=1).
  - PEND_LOW: mirror of PEND_HIGH.
  - DEBOUNCE_CYCLES=1: LOW/HIGH go directly to HIGH/LOW on the first mismatching s; PEND states are never entered.
- Outputs (all registered, driven from the FSM):
  - D_clean = 1 in HIGH or PEND_LOW.
  - Busy = 1 in PEND_HIGH or PEND_LOW.
  - Rise and Fall assert for exactly one cycle, in the same cycle D_clean changes.
  - Rise and Fall are never both high.
- Latency: with D_raw held at the new level, D_clean changes after the (SYNC_STAGES+DEBOUNCE_CYCLES)th rising edge that samples the new level. Defaults: 6th edge.
- Bounce: any glitch that returns s to D_clean's level before qualification completes restarts qualification from zero. A glitch shorter than one clock may or may not be captured; either outcome is legal, and D_clean must never toggle from it.
- Reset release with D_raw=1: D_clean starts at 0, then rises after the full latency with a Rise pulse. This is required behaviour, not suppressed.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around possible.

Decomposition:
- Shared package/include holds:
  - FSM state encodings: LOW=2'd0, PEND_HIGH=2'd1, HIGH=2'd2, PEND_LOW=2'd3.
  - Default parameter constants for SYNC_STAGES and DEBOUNCE_CYCLES.
- One sub-module, sync_chain:
  - Parameterised by SYNC_STAGES.
  - Ports: Clock, Resetn, d, q.
  - Reusable by other asynchronous inputs.
- The FSM and counter stay in input_conditioner.

Test Plan (defaults unless stated):
- Reset, then D_raw=0 for 20 cycles -> D_clean=0, Rise=Fall=Busy=0 throughout.
- D_raw 0->1 held -> Busy rises on edge 3; D_clean=1 and Rise=1 on edge 6 only; Rise=0 on edge 7.
- D_raw=1 for 2 cycles, 0 for 1, then 1 held -> no pulse from the first burst; Busy drops on the glitch; D_clean=1 six edges after the final 0->1.
- From HIGH, D_raw 1->0 held -> Fall single pulse with D_clean=0 on edge 6; Rise stays 0.
- Resetn asserted mid-PEND_HIGH (edge 4 of qualification) -> all outputs 0 immediately, no pulse. After release with D_raw=1, Rise occurs 6 edges later.
- DEBOUNCE_CYCLES=1, SYNC_STAGES=3, D_raw 0->1 -> D_clean=1 and Rise on edge 4; Busy never asserts.
